// File: rtl/adder_share_arb.sv
// adder_share_arb: two-requester round-robin front end for one shared external adder.
// Define ADDER_SELF_CHECK_EN to check the adder result against a local sum.
module adder_share_arb #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [2*n-1:0] req_a,
    input  logic [2*n-1:0] req_b,
    input  logic [1:0]   req_cin,
    output logic [n-1:0] add_a,
    output logic [n-1:0] add_b,
    output logic         add_cin,
    input  logic [n-1:0] add_s,
    input  logic         add_cout,
    input  logic         add_prop,
    input  logic         add_gen,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [n-1:0] res_s,
    output logic         res_cout,
    output logic         res_prop,
    output logic         res_gen,
    output logic         res_id,
    output logic         busy,
    output logic         err_flag,
    output logic [15:0]  err_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nx;
    logic last_gnt, gnt, op_cin, accept;
    logic [n-1:0] op_a, op_b;
    always_comb begin
        gnt = (&req_valid) ? ~last_gnt : req_valid[1];
        accept = state == IDLE && |req_valid;
        req_ready = (accept && rst_n) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        state_nx = state;
        unique case (state)
            IDLE: if (|req_valid) state_nx = EXEC;
            EXEC: state_nx = DONE;
            DONE: if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    assign add_a = op_a;
    assign add_b = op_b;
    assign add_cin = op_cin;
    assign res_valid = state == DONE;
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last_gnt <= 1'b1;
            op_a <= '0;
            op_b <= '0;
            op_cin <= 1'b0;
            res_s <= '0;
            res_cout <= 1'b0;
            res_prop <= 1'b0;
            res_gen <= 1'b0;
            res_id <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_a <= gnt ? req_a[n +: n] : req_a[0 +: n];
                op_b <= gnt ? req_b[n +: n] : req_b[0 +: n];
                op_cin <= req_cin[gnt];
                res_id <= gnt;
                last_gnt <= gnt;
            end
            if (state == EXEC) begin
                res_s <= add_s;
                res_cout <= add_cout;
                res_prop <= add_prop;
                res_gen <= add_gen;
            end
        end
    end
`ifdef ADDER_SELF_CHECK_EN
    logic [n:0] ref_sum;
    assign ref_sum = {1'b0, op_a} + {1'b0, op_b} + {{n{1'b0}}, op_cin};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
            err_cnt <= '0;
        end else if (state == EXEC && {add_cout, add_s} != ref_sum) begin
            err_flag <= 1'b1;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    assign err_flag = 1'b0;
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed-vector bench for adder_share_arb with a behavioural shared adder.
module tb_adder_share_arb;
    localparam int n = 16;
    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] req_valid, req_ready, req_cin;
    logic [2*n-1:0] req_a, req_b;
    logic [n-1:0] add_a, add_b, add_s, res_s;
    logic add_cin, add_cout, add_prop, add_gen;
    logic res_valid, res_ready, res_cout, res_prop, res_gen, res_id, busy, err_flag;
    logic [15:0] err_cnt;
    logic inject;
    logic [n:0] full, gen_sum;
    int n_checks = 0;
    int n_fails = 0;

    always #5 clk = ~clk;

    assign full = {1'b0, add_a} + {1'b0, add_b} + {{n{1'b0}}, add_cin};
    assign gen_sum = {1'b0, add_a} + {1'b0, add_b};
    assign add_s = full[n-1:0] ^ {{(n-1){1'b0}}, inject};
    assign add_cout = full[n];
    assign add_prop = &(add_a ^ add_b);
    assign add_gen = gen_sum[n];

    adder_share_arb #(.n(n)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s),
        .add_cout(add_cout), .add_prop(add_prop), .add_gen(add_gen),
        .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s),
        .res_cout(res_cout), .res_prop(res_prop), .res_gen(res_gen),
        .res_id(res_id), .busy(busy), .err_flag(err_flag), .err_cnt(err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op(input string tag, input logic [1:0] v, input logic [1:0] exp_rdy,
                      input logic [n:0] exp_sum, input logic exp_p, input logic exp_g,
                      input logic exp_id);
        @(negedge clk);
        req_valid = v;
        #1 check({tag, " grant"}, 32'(req_ready), 32'(exp_rdy));
        @(negedge clk);
        req_valid = 2'b00;
        #1 check({tag, " exec"}, {29'd0, busy, req_ready}, {29'd0, 1'b1, 2'b00});
        check({tag, " exec valid"}, 32'(res_valid), 32'd0);
        @(negedge clk);
        #1 check({tag, " valid"}, 32'(res_valid), 32'd1);
        check({tag, " sum"}, 32'({res_cout, res_s}), 32'(exp_sum));
        check({tag, " pg id"}, {29'd0, res_prop, res_gen, res_id}, {29'd0, exp_p, exp_g, exp_id});
        @(negedge clk);
        #1 check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_a = '0;
        req_b = '0;
        req_cin = 2'b00;
        res_ready = 1'b1;
        inject = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset ctl", {29'd0, req_ready, busy}, 32'd0);
        check("reset valid", 32'(res_valid), 32'd0);
        check("reset err", {15'd0, err_flag, err_cnt}, 32'd0);
        check("reset res", {14'd0, res_cout, res_id, res_s}, 32'd0);
        rst_n = 1'b1;

        req_a[15:0] = 16'h00FF; req_b[15:0] = 16'h0001; req_cin[0] = 1'b0;
        op("basic", 2'b01, 2'b01, 17'h00100, 1'b0, 1'b0, 1'b0);

        req_a[31:16] = 16'hFFFF; req_b[31:16] = 16'h0000; req_cin[1] = 1'b1;
        op("wrap", 2'b10, 2'b10, 17'h10000, 1'b1, 1'b0, 1'b1);
        check("no err", {15'd0, err_flag, err_cnt}, 32'd0);

        req_a[15:0] = 16'h1234; req_b[15:0] = 16'h4321; req_cin[0] = 1'b1;
        @(negedge clk);
        req_valid = 2'b01;
        res_ready = 1'b0;
        #1 check("stall grant", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1 check("stall valid", 32'(res_valid), 32'd1);
            check("stall sum", 32'({res_cout, res_s}), 32'h05556);
            check("stall ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        #1 check("stall release", 32'(busy), 32'd0);
        check("pending grant", 32'(req_ready), 32'd1);
        req_valid = 2'b00;

        req_a[15:0] = 16'h0003; req_b[15:0] = 16'h0004; req_cin[0] = 1'b0;
        inject = 1'b1;
        for (int i = 0; i < 3; i++) op("fault", 2'b01, 2'b01, 17'h00006, 1'b0, 1'b0, 1'b0);
        inject = 1'b0;
`ifdef ADDER_SELF_CHECK_EN
        check("err after faults", {15'd0, err_flag, err_cnt}, {15'd0, 1'b1, 16'd3});
`else
        check("err after faults", {15'd0, err_flag, err_cnt}, 32'd0);
`endif

        @(negedge clk);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        #1 check("pre-reset exec", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        #1 check("mid reset", {29'd0, busy, res_valid, req_ready[0]}, 32'd0);
        check("mid reset err", {15'd0, err_flag, err_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1 check("no result", {30'd0, busy, res_valid}, 32'd0);
        end

        req_a = {16'h8000, 16'h1111};
        req_b = {16'h8000, 16'h2222};
        req_cin = 2'b10;
        @(negedge clk);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 check("rr grant", 32'(req_ready), k[0] ? 32'd2 : 32'd1);
            @(negedge clk);
            #1 check("rr exec", 32'(req_ready), 32'd0);
            @(negedge clk);
            #1 check("rr id", 32'(res_id), 32'(k[0]));
            check("rr sum", 32'({res_cout, res_s}), k[0] ? 32'h10001 : 32'h03333);
            check("rr gen", 32'(res_gen), 32'(k[0]));
            @(negedge clk);
        end
        req_valid = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/adder_share_arb.md
ADDER_SHARE_ARB -- requirements
Module: adder_share_arb

Interface
REQ-001 SHALL have parameter n, default 16, operand width of the shared adder.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  2  per-requester operation request, bit i = requester i.
REQ-005 SHALL have port req_ready  output  2  per-requester accept; one-hot or zero.
REQ-006 SHALL have port req_a  input  2n  operands a, requester i at bits [i*n +: n].
REQ-007 SHALL have port req_b  input  2n  operands b, same packing as req_a.
REQ-008 SHALL have port req_cin  input  2  carry-in, bit i = requester i.
REQ-009 SHALL have port add_a, add_b  output  n each  operands driven to the shared external adder.
REQ-010 SHALL have port add_cin  output  1  carry-in to the shared adder.
REQ-011 SHALL have port add_s  input  n  shared adder sum.
REQ-012 SHALL have port add_cout, add_prop, add_gen  input  1 each  shared adder carry-out, group propagate, group generate.
REQ-013 SHALL have port res_valid  output  1  result available.
REQ-014 SHALL have port res_ready  input  1  result consumer accept.
REQ-015 SHALL have port res_s  output  n, and res_cout, res_prop, res_gen  output  1 each  registered adder result.
REQ-016 SHALL have port res_id  output  1  index of requester owning the result.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-018 SHALL have port err_flag  output  1, and err_cnt  output  16  self-check status (see Configuration).

Function
REQ-019 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-020 IDLE: if any req_valid, SHALL assert req_ready for the granted requester only (combinational, same cycle), latch its a, b, cin into operand registers and its index into res_id, go to EXEC; else stay IDLE.
REQ-021 Arbitration SHALL be round-robin: with both requests valid, grant the requester not granted last; single request always granted.
REQ-022 add_a, add_b, add_cin SHALL always equal the operand registers.
REQ-023 EXEC: SHALL capture add_s, add_cout, add_prop, add_gen into res_* registers and go to DONE (adder treated as single-cycle combinational).
REQ-024 DONE: res_valid SHALL be high; on res_ready high go to IDLE, else hold all res_* stable.
REQ-025 Latency SHALL be accept edge -> res_valid high 2 cycles later; peak throughput one operation per 3 cycles when res_ready is held high.
REQ-026 req_ready SHALL be 0 in EXEC and DONE; requests arriving then wait, no request is dropped while valid is held.
REQ-027 A requester deasserting req_valid before grant SHALL simply not be granted; no state change.

Reset
REQ-028 On rst_n low at a clk edge SHALL enter IDLE, clear operand and res_* registers, res_id, err_flag, err_cnt to 0, and set last-grant to 1 so requester 0 wins the first tie.
REQ-029 Reset during EXEC or DONE SHALL discard the operation; no res_valid follows.
REQ-030 req_ready, res_valid, busy SHALL be 0 in the cycle after reset is applied.

Configuration
REQ-031 Macro ADDER_SELF_CHECK_EN SHALL enable the checker: in EXEC compare {add_cout, add_s} against the (n+1)-bit sum a+b+cin of the operand registers.
REQ-032 With ADDER_SELF_CHECK_EN: mismatch SHALL set err_flag (sticky until reset) and increment err_cnt, saturating at 16'hFFFF.
REQ-033 Without ADDER_SELF_CHECK_EN: err_flag and err_cnt SHALL be tied to 0; all other behaviour identical.

Verification (n=16)
REQ-034 req_valid=01, a=16'h00FF, b=16'h0001, cin=0, res_ready=1 -> req_ready=01 same cycle; 2 cycles later res_valid=1, res_s=16'h0100, res_cout=0, res_id=0.
REQ-035 req_valid=11 held, both requests repeated -> grants alternate 0,1,0,1 starting with 0; res_id matches grant order.
REQ-036 a=16'hFFFF, b=16'h0000, cin=1 -> res_s=16'h0000, res_cout=1, res_prop=1, res_gen=0 from a correct adder.
REQ-037 res_ready=0 for 5 cycles in DONE -> res_valid and res_* stable, req_ready=00; then res_ready=1 -> IDLE next cycle.
REQ-038 rst_n low during EXEC -> next cycle busy=0, res_valid=0, err_cnt=0; no result produced.
REQ-039 With ADDER_SELF_CHECK_EN, adder model forcing add_s bit 0 inverted on 3 operations -> err_flag=1, err_cnt=3; without macro, err_flag=0, err_cnt=0.
